// File: rtl/qam_pkg.sv
// Shared definitions for the QAM sample path.
//   SAMPLE_W      : bits per signed sample
//   CNT_W         : width of the in-sample bit counter
//   sample_t      : signed sample word, MSB is the sign bit
//   deser_state_t : framing state of the deserializer
package qam_pkg;

    localparam int unsigned SAMPLE_W = 8;
    localparam int unsigned CNT_W    = $clog2(SAMPLE_W);

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic {
        SYNC     = 1'b0,
        ASSEMBLE = 1'b1
    } deser_state_t;

endpackage

// File: rtl/qam_sample_fifo.sv
// Small synchronous FIFO of signed samples with a registered head.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   push_i    : write data_i (ignored when full unless popping in the same cycle)
//   data_i    : sample to write
//   pop_i     : advance the head (ignored when empty)
//   data_o    : head sample, '0 while empty
//   full_o    : DEPTH entries held
//   empty_o   : no entries held
module qam_sample_fifo
    import qam_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push_i,
    input  sample_t data_i,
    input  logic    pop_i,
    output sample_t data_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    sample_t         mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic            do_push;
    logic            do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));

    // A pop frees a slot in the same cycle, so a push into a full FIFO
    // is accepted when it coincides with a pop.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/qam_sample_deserializer.sv
// Re-assembles LSB-first serial samples from the QAM modulator, checks
// framing against the sample-complete strobe and buffers finished samples
// in a FIFO behind a valid/ready interface.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   bit_in        : serial data bit, one per clock
//   bit_last      : strobe marking the final (MSB) bit of a sample
//   sample_out    : signed sample at FIFO head ('0 when empty)
//   sample_valid  : FIFO non-empty
//   sample_ready  : consumer takes the head when valid & ready
//   locked        : framing aligned
//   frame_err     : one-cycle pulse on a framing violation
//   overflow      : sticky, a completed sample was dropped on a full FIFO
//   err_count     : saturating frame-error counter (only with QAM_DESER_ERRCNT_EN)
// Build option: define QAM_DESER_ERRCNT_EN to add err_count.
module qam_sample_deserializer
    import qam_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_in,
    input  logic        bit_last,
    output sample_t     sample_out,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        locked,
    output logic        frame_err,
    output logic        overflow
`ifdef QAM_DESER_ERRCNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SAMPLE_W - 1);

    deser_state_t          state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    // The MSB never needs storing: it arrives with the strobe and goes
    // straight into the pushed word.
    logic [SAMPLE_W-2:0]   shift_q, shift_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overflow_q, overflow_d;
    logic                  push;
    sample_t               word;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        word        = {bit_in, shift_q};
        case (state_q)
            SYNC: begin
                if (bit_last) begin
                    state_d = ASSEMBLE;
                    count_d = '0;
                end
            end
            ASSEMBLE: begin
                if (count_q == LAST_IDX) begin
                    count_d = '0;
                    shift_d = '0;
                    if (bit_last) begin
                        push = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = SYNC;
                    end
                end else if (bit_last) begin
                    // Early strobe: drop the partial word but treat this
                    // strobe as the new alignment point.
                    frame_err_d = 1'b1;
                    count_d     = '0;
                    shift_d     = '0;
                end else begin
                    shift_d[count_q] = bit_in;
                    count_d          = count_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = SYNC;
                count_d = '0;
            end
        endcase
    end

    assign pop        = sample_valid & sample_ready;
    assign overflow_d = overflow_q | (push & fifo_full & ~pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SYNC;
            count_q     <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    qam_sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (word),
        .pop_i   (pop),
        .data_o  (sample_out),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign sample_valid = ~fifo_empty;
    assign locked       = (state_q == ASSEMBLE);
    assign frame_err    = frame_err_q;
    assign overflow     = overflow_q;

`ifdef QAM_DESER_ERRCNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (frame_err_d && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_qam_sample_deserializer.sv
module tb_qam_sample_deserializer;

    logic              clk;
    logic              rst;
    logic              bit_in;
    logic              bit_last;
    logic signed [7:0] sample_out;
    logic              sample_valid;
    logic              sample_ready;
    logic              locked;
    logic              frame_err;
    logic              overflow;
`ifdef QAM_DESER_ERRCNT_EN
    logic [15:0]       err_count;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned err_seen = 0;
    logic [7:0]  sb [$];

    qam_sample_deserializer #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bit_in       (bit_in),
        .bit_last     (bit_last),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .locked       (locked),
        .frame_err    (frame_err),
        .overflow     (overflow)
`ifdef QAM_DESER_ERRCNT_EN
        ,
        .err_count    (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; returns 1 unit after
    // the edge that consumed them.
    task automatic drive_bit(input logic b, input logic l);
        bit_in   = b;
        bit_last = l;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w, input bit expect_push);
        if (expect_push) sb.push_back(w);
        for (int i = 0; i < 8; i++) begin
            drive_bit(w[i], i == 7);
        end
    endtask

    // Scoreboard: every accepted head must be the oldest expected sample.
    always @(negedge clk) begin
        if (!rst && sample_valid && sample_ready) begin
            if (sb.size() == 0) begin
                check_eq("sb_unexpected_pop", sb.size(), 1);
            end else begin
                check_eq("sb_sample", $unsigned(sample_out), sb.pop_front());
            end
        end
        if (!rst && frame_err) err_seen++;
    end

    initial begin
        rst          = 1'b1;
        bit_in       = 1'b0;
        bit_last     = 1'b0;
        sample_ready = 1'b1;
        #1;
        check_eq("rst_valid", sample_valid, 0);
        check_eq("rst_out", $unsigned(sample_out), 0);
        check_eq("rst_locked", locked, 0);
        check_eq("rst_ferr", frame_err, 0);
        check_eq("rst_ovf", overflow, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Aligned stream
        drive_bit(1'b0, 1'b1);
        check_eq("lock_after_sync", locked, 1);
        send_word(8'h5A, 1'b1);
        check_eq("5a_valid", sample_valid, 1);
        check_eq("5a_out", $unsigned(sample_out), 8'h5A);

        // Signed values, back to back
        send_word(8'hF3, 1'b1);
        check_eq("f3_signed", int'(sample_out), -13);
        send_word(8'h7F, 1'b1);
        check_eq("7f_signed", int'(sample_out), 127);
        check_eq("no_ferr_aligned", err_seen, 0);

        // Early last on bit 3
        drive_bit(1'b0, 1'b0);
        check_eq("valid_one_cycle", sample_valid, 0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b1);
        check_eq("early_ferr", frame_err, 1);
        check_eq("early_locked", locked, 1);
        send_word(8'h21, 1'b1);
        check_eq("ferr_one_cycle", frame_err, 0);
        check_eq("21_out", $unsigned(sample_out), 8'h21);
        check_eq("early_err_cnt", err_seen, 1);

        // Missing last
        for (int i = 0; i < 8; i++) drive_bit(i[0], 1'b0);
        check_eq("miss_ferr", frame_err, 1);
        check_eq("miss_locked", locked, 0);
        check_eq("miss_valid", sample_valid, 0);
        for (int i = 0; i < 8; i++) drive_bit(1'b1, 1'b0);
        check_eq("sync_ignores_bits", locked, 0);
        drive_bit(1'b0, 1'b1);
        check_eq("relock", locked, 1);

        // Backpressure and overflow
        sample_ready = 1'b0;
        send_word(8'hA1, 1'b1);
        send_word(8'hA2, 1'b1);
        send_word(8'hA3, 1'b1);
        send_word(8'hA4, 1'b1);
        check_eq("full_no_ovf", overflow, 0);
        send_word(8'hA5, 1'b0);
        check_eq("ovf_set", overflow, 1);
        check_eq("ovf_valid", sample_valid, 1);
        check_eq("ovf_head", $unsigned(sample_out), 8'hA1);
        sample_ready = 1'b1;
        repeat (4) drive_bit(1'b0, 1'b0);
        check_eq("drained", sample_valid, 0);
        check_eq("drain_sb", sb.size(), 0);
        drive_bit(1'b0, 1'b1);
        check_eq("ferr3", frame_err, 1);
        check_eq("ovf_sticky", overflow, 1);

        // Reset mid-sample with two samples buffered
        sample_ready = 1'b0;
        send_word(8'hB1, 1'b0);
        send_word(8'hB2, 1'b0);
        check_eq("hold_head", $unsigned(sample_out), 8'hB1);
        repeat (3) drive_bit(1'b1, 1'b0);
        check_eq("err_total", err_seen, 3);
`ifdef QAM_DESER_ERRCNT_EN
        check_eq("err_count_3", err_count, 3);
`endif
        #2 rst = 1'b1;
        #1;
        check_eq("arst_valid", sample_valid, 0);
        check_eq("arst_out", $unsigned(sample_out), 0);
        check_eq("arst_locked", locked, 0);
        check_eq("arst_ovf", overflow, 0);
        check_eq("arst_ferr", frame_err, 0);
`ifdef QAM_DESER_ERRCNT_EN
        check_eq("err_count_rst", err_count, 0);
`endif
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        sample_ready = 1'b1;
        for (int i = 0; i < 8; i++) drive_bit(1'b1, 1'b0);
        check_eq("post_rst_unlocked", locked, 0);
        check_eq("post_rst_novalid", sample_valid, 0);
        drive_bit(1'b0, 1'b1);
        check_eq("post_rst_novalid2", sample_valid, 0);
        send_word(8'hC3, 1'b1);
        check_eq("c3_valid", sample_valid, 1);
        check_eq("c3_out", $unsigned(sample_out), 8'hC3);
        drive_bit(1'b0, 1'b0);
        check_eq("final_sb_empty", sb.size(), 0);
        check_eq("final_empty", sample_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
